// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the div_ctrl programmable clock divider.
//   state_e    : controller states (IDLE, RUN, SWITCH, DRAIN)
//   CNT_W      : width of the period counter
//   SEL_MAX    : largest legal ratio code (ratio = 2^(sel+1))
//   sel_bit    : counter bit that forms div_out for a given ratio code
//   period_end : true on the last cycle of a div_out period
package div_ctrl_pkg;

   localparam int CNT_W = 5;
   localparam int SEL_W = 3;
   localparam logic [SEL_W-1:0] SEL_MAX = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SWITCH = 2'd2,
      ST_DRAIN  = 2'd3
   } state_e;

   // Counter bit selected by the ratio code; codes above SEL_MAX never reach
   // cur_sel, so they simply map onto the top bit.
   function automatic logic sel_bit(input logic [CNT_W-1:0] cnt,
                                    input logic [SEL_W-1:0] sel);
      logic b;
      case (sel)
         3'd0:    b = cnt[0];
         3'd1:    b = cnt[1];
         3'd2:    b = cnt[2];
         3'd3:    b = cnt[3];
         default: b = cnt[4];
      endcase
      return b;
   endfunction

   // Period end: cnt[sel:0] all ones.
   function automatic logic period_end(input logic [CNT_W-1:0] cnt,
                                       input logic [SEL_W-1:0] sel);
      logic [CNT_W-1:0] mask;
      case (sel)
         3'd0:    mask = 5'b00001;
         3'd1:    mask = 5'b00011;
         3'd2:    mask = 5'b00111;
         3'd3:    mask = 5'b01111;
         default: mask = 5'b11111;
      endcase
      return &(cnt | ~mask);
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Handshake/status bundle of div_ctrl.
//   en, cfg_valid, cfg_sel            : driven by the master (controller user)
//   cfg_ready, div_out, tick, cur_sel,
//   busy, err                         : driven by the slave (div_ctrl)
interface div_ctrl_if;
   import div_ctrl_pkg::*;

   logic             en;
   logic             cfg_valid;
   logic [SEL_W-1:0] cfg_sel;
   logic             cfg_ready;
   logic             div_out;
   logic             tick;
   logic [SEL_W-1:0] cur_sel;
   logic             busy;
   logic             err;

   modport master (
      output en, cfg_valid, cfg_sel,
      input  cfg_ready, div_out, tick, cur_sel, busy, err
   );

   modport slave (
      input  en, cfg_valid, cfg_sel,
      output cfg_ready, div_out, tick, cur_sel, busy, err
   );

endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: power-of-two clock divider (div2..div32) with glitch-free ratio
// switching. Ratio changes requested while running are held until the end of
// the current div_out period so no phase is ever cut short.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_ctrl_if.slave (en/cfg handshake in; div_out, tick, status out)
// All outputs come straight from flops, computed from next-state values.
module div_ctrl
   import div_ctrl_pkg::*;
(
   input logic     clk,
   input logic     rst,
   div_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
   logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
   logic             pend_vld_q, pend_vld_d;
   logic             err_d;

   logic             div_out_q, tick_q, cfg_ready_q, busy_q, err_q;

   logic             cfg_acc_s, cfg_legal_s, per_end_s;

   assign cfg_acc_s   = bus.cfg_valid && cfg_ready_q;
   assign cfg_legal_s = (bus.cfg_sel <= SEL_MAX);
   assign per_end_s   = period_end(cnt_q, cur_sel_q);

   // Next-state logic for the controller and its counter.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_sel_d  = cur_sel_q;
      pend_sel_d = pend_sel_q;
      pend_vld_d = pend_vld_q;
      err_d      = cfg_acc_s && !cfg_legal_s;

      case (state_q)
         ST_IDLE: begin
            if (cfg_acc_s && cfg_legal_s) begin
               cur_sel_d = bus.cfg_sel;
            end else begin
               cur_sel_d = cur_sel_q;
            end
            if (bus.en) begin
               state_d = ST_RUN;
               cnt_d   = 5'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            cnt_d = cnt_q + 5'd1;
            if (cfg_acc_s && cfg_legal_s) begin
               pend_sel_d = bus.cfg_sel;
               pend_vld_d = 1'b1;
            end else begin
               pend_vld_d = pend_vld_q;
            end
            // Dropping en wins over a simultaneous ratio request; the
            // request stays pending and is applied when the drain ends.
            if (!bus.en) begin
               state_d = ST_DRAIN;
            end else if (cfg_acc_s && cfg_legal_s) begin
               state_d = ST_SWITCH;
            end else begin
               state_d = ST_RUN;
            end
         end

         ST_SWITCH: begin
            cnt_d = cnt_q + 5'd1;
            if (!bus.en) begin
               state_d = ST_DRAIN;
            end else if (per_end_s) begin
               // Applied even when the new ratio equals the old one.
               cur_sel_d  = pend_sel_q;
               pend_vld_d = 1'b0;
               cnt_d      = 5'd0;
               state_d    = ST_RUN;
            end else begin
               state_d = ST_SWITCH;
            end
         end

         ST_DRAIN: begin
            cnt_d = cnt_q + 5'd1;
            // en is ignored here: a started drain always completes.
            if (per_end_s) begin
               if (pend_vld_q) begin
                  cur_sel_d = pend_sel_q;
               end else begin
                  cur_sel_d = cur_sel_q;
               end
               pend_vld_d = 1'b0;
               cnt_d      = 5'd0;
               state_d    = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            cnt_d      = 5'd0;
            pend_vld_d = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 5'd0;
         cur_sel_q   <= 3'd0;
         pend_sel_q  <= 3'd0;
         pend_vld_q  <= 1'b0;
         div_out_q   <= 1'b0;
         tick_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_sel_q   <= cur_sel_d;
         pend_sel_q  <= pend_sel_d;
         pend_vld_q  <= pend_vld_d;
         div_out_q   <= (state_d != ST_IDLE) && sel_bit(cnt_d, cur_sel_d);
         tick_q      <= (state_d != ST_IDLE) && period_end(cnt_d, cur_sel_d);
         cfg_ready_q <= (state_d == ST_IDLE) || (state_d == ST_RUN);
         busy_q      <= (state_d != ST_IDLE);
         err_q       <= err_d;
      end
   end

   assign bus.cfg_ready = cfg_ready_q;
   assign bus.div_out   = div_out_q;
   assign bus.tick      = tick_q;
   assign bus.cur_sel   = cur_sel_q;
   assign bus.busy      = busy_q;
   assign bus.err       = err_q;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: en  in  1  run request; high = generate divided output.
REQ-004 SHALL have ports: cfg_valid  in  1  ratio-change request valid.
REQ-005 SHALL have ports: cfg_sel  in  3  requested ratio code k; ratio = 2^(k+1); legal 0..4 (div2..div32).
REQ-006 SHALL have ports: cfg_ready  out  1  config accepted when cfg_valid && cfg_ready at a rising edge.
REQ-007 SHALL have ports: div_out  out  1  50%-duty divided output.
REQ-008 SHALL have ports: tick  out  1  one-cycle pulse on the last cycle of each div_out period.
REQ-009 SHALL have ports: cur_sel  out  3  ratio code currently in effect.
REQ-010 SHALL have ports: busy  out  1  high in any state other than IDLE.
REQ-011 SHALL have ports: err  out  1  one-cycle pulse, the cycle after an illegal cfg_sel (5..7) is accepted.

Function
REQ-012 SHALL implement states IDLE, RUN, SWITCH, DRAIN.
REQ-013 SHALL keep a 5-bit counter cnt, cleared on every entry to RUN and incremented by 1 (mod 32) every cycle in RUN, SWITCH and DRAIN.
REQ-014 SHALL drive div_out = cnt[cur_sel] in RUN, SWITCH and DRAIN; div_out = 0 in IDLE.
REQ-015 SHALL define period end as a non-IDLE cycle with cnt[cur_sel:0] all ones; tick = 1 exactly on those cycles.
REQ-016 SHALL drive cfg_ready = 1 in IDLE and RUN, 0 in SWITCH and DRAIN.
REQ-017 IDLE: accepted legal config updates cur_sel at that edge; en = 1 moves to RUN with cnt = 0 next cycle.
REQ-018 RUN: accepted legal config stores pend_sel and moves to SWITCH; cur_sel unchanged.
REQ-019 SWITCH: at period end, cur_sel <= pend_sel, cnt <= 0, return to RUN; this happens even if pend_sel == cur_sel.
REQ-020 RUN or SWITCH with en = 0 SHALL move to DRAIN; a stored pend_sel is kept.
REQ-021 DRAIN: at period end, apply any pending pend_sel to cur_sel, clear cnt, go to IDLE; en re-asserted during DRAIN does not abort the drain.
REQ-022 Simultaneous accepted config and en = 0 in RUN SHALL store pend_sel and enter DRAIN (drain has priority).
REQ-023 Accepted illegal cfg_sel SHALL complete the handshake, pulse err, and leave state, cur_sel and pend_sel unchanged.
REQ-024 div_out SHALL never produce a high or low phase shorter than 2^min(old,new) cycles across a switch.

Reset
REQ-025 On rst: state = IDLE, cnt = 0, cur_sel = 0, pend_sel = 0, div_out = 0, tick = 0, err = 0, busy = 0, cfg_ready = 1.
REQ-026 rst SHALL override all other inputs in any state, including mid-SWITCH and mid-DRAIN; pending config is discarded.

Structure
REQ-027 SHALL place the state enum, CNT_W = 5 and SEL_MAX = 4 in shared package div_ctrl_pkg.
REQ-028 SHALL be a single module with no sub-modules; all outputs derived from registered state.

Verification
REQ-029 Reset, then en = 1 with cur_sel = 0 -> div_out toggles every cycle, tick every 2nd cycle, busy = 1.
REQ-030 In IDLE, cfg_sel = 2 accepted, then en = 1 -> div_out low 4 and high 4 cycles, tick every 8 cycles, cur_sel = 2.
REQ-031 In RUN at div4, cfg_sel = 4 accepted mid-period -> cfg_ready = 0 until period end; then div32 starts with cnt = 0, tick every 32 cycles.
REQ-032 In RUN at div16, en = 0 at cnt = 3 -> DRAIN, div_out continues until cnt = 15 (tick), then IDLE with div_out = 0, busy = 0.
REQ-033 cfg_sel = 6 accepted in RUN -> err pulses for one cycle, state stays RUN, cur_sel unchanged.
REQ-034 rst asserted in SWITCH -> next cycle all outputs at REQ-025 values; the pending ratio is never applied.
